// File: rtl/multi_pulse_stretch.sv
// Multi-channel debug pulse stretcher: optional input synchroniser, per-channel
// polarity, rising-edge detect, fixed-length stretch, saturating edge counters.
module multi_pulse_stretch #(
  parameter int                 NUM_CH         = 4,
  parameter int                 STRETCH_CYCLES = 10,
  parameter int                 SYNC_STAGES    = 2,
  parameter int                 RETRIGGER      = 0,
  parameter logic [NUM_CH-1:0]  IN_INVERT      = '0,
  parameter int                 CNT_WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        nReset,
  input  logic [NUM_CH-1:0]           in_pulse,
  input  logic                        clr_counts,
  output logic [NUM_CH-1:0]           out_pulse,
  output logic [NUM_CH*CNT_WIDTH-1:0] edge_count,
  output logic [NUM_CH-1:0]           overrun
);

  localparam int CW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [CW-1:0]        RELOAD  = CW'(STRETCH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0]    x;
  logic [NUM_CH-1:0]    s;
  logic [NUM_CH-1:0]    p;
  logic [NUM_CH-1:0]    rise;
  logic [NUM_CH-1:0]    out_q;
  logic [NUM_CH-1:0]    ovr_q;
  logic [CW-1:0]        cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] ec_q  [NUM_CH];

  // Inversion happens before synchronisation so every channel sees active-high.
  assign x = in_pulse ^ IN_INVERT;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = x;
    end else begin : g_sync
      logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= x;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // p resets low, so an input held asserted through reset yields one pulse.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) p <= '0;
    else         p <= s;
  end

  assign rise = s & ~p;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      out_q <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rise[i] && (!out_q[i] || (RETRIGGER != 0))) begin
          out_q[i] <= 1'b1;
          cnt_q[i] <= RELOAD;
        end else if (out_q[i]) begin
          // Non-retriggering edges during a pulse fall through to the countdown.
          if (cnt_q[i] == '0) out_q[i] <= 1'b0;
          else                cnt_q[i] <= cnt_q[i] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      ovr_q <= '0;
      for (int i = 0; i < NUM_CH; i++) ec_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_counts) begin
          // An edge coinciding with the clear is kept rather than dropped.
          ec_q[i]  <= rise[i] ? CNT_WIDTH'(1) : '0;
          ovr_q[i] <= rise[i] & out_q[i];
        end else begin
          if (rise[i] && (ec_q[i] != CNT_MAX)) ec_q[i] <= ec_q[i] + CNT_WIDTH'(1);
          if (rise[i] && out_q[i])             ovr_q[i] <= 1'b1;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign edge_count[g*CNT_WIDTH +: CNT_WIDTH] = ec_q[g];
    end
  endgenerate

  assign out_pulse = out_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_multi_pulse_stretch.sv
// Directed bench for multi_pulse_stretch across three parameter sets; expected
// out_pulse per cycle is queued with the stimulus and compared as it emerges.
module tb_multi_pulse_stretch;

  logic clk;
  logic nReset;

  // dut_a: no sync, no retrigger, 4-bit counters
  logic [3:0]  in_a;
  logic        clr_a;
  logic [3:0]  out_a;
  logic [15:0] ec_a;
  logic [3:0]  ov_a;
  // dut_b: 2-stage sync, retrigger, ch2 active-low
  logic [3:0]  in_b;
  logic        clr_b;
  logic [3:0]  out_b;
  logic [31:0] ec_b;
  logic [3:0]  ov_b;
  // dut_c: single channel, 1-cycle stretch
  logic [0:0]  in_c;
  logic        clr_c;
  logic [0:0]  out_c;
  logic [7:0]  ec_c;
  logic [0:0]  ov_c;

  int checks = 0;
  int errors = 0;

  logic [4:0] stim_q[$];
  logic [3:0] exp_q[$];

  multi_pulse_stretch #(.NUM_CH(4), .STRETCH_CYCLES(10), .SYNC_STAGES(0), .RETRIGGER(0),
                        .IN_INVERT(4'b0000), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .nReset(nReset), .in_pulse(in_a), .clr_counts(clr_a),
    .out_pulse(out_a), .edge_count(ec_a), .overrun(ov_a));

  multi_pulse_stretch #(.NUM_CH(4), .STRETCH_CYCLES(10), .SYNC_STAGES(2), .RETRIGGER(1),
                        .IN_INVERT(4'b0100), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .nReset(nReset), .in_pulse(in_b), .clr_counts(clr_b),
    .out_pulse(out_b), .edge_count(ec_b), .overrun(ov_b));

  multi_pulse_stretch #(.NUM_CH(1), .STRETCH_CYCLES(1), .SYNC_STAGES(0), .RETRIGGER(0),
                        .IN_INVERT(1'b0), .CNT_WIDTH(8)) dut_c (
    .clk(clk), .nReset(nReset), .in_pulse(in_c), .clr_counts(clr_c),
    .out_pulse(out_c), .edge_count(ec_c), .overrun(ov_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] st, input logic [3:0] ex);
    stim_q.push_back(st);
    exp_q.push_back(ex);
  endtask

  // Drive one queued stimulus per cycle on the chosen DUT and compare its
  // out_pulse at the following falling edge.
  task run_seq(input int dut, input string tag);
    logic [4:0] st;
    logic [3:0] e;
    logic [3:0] obs;
    while (stim_q.size() > 0) begin
      st = stim_q.pop_front();
      case (dut)
        0:       begin in_a = st[3:0]; clr_a = st[4]; end
        1:       begin in_b = st[3:0]; clr_b = st[4]; end
        default: begin in_c = st[0];   clr_c = st[4]; end
      endcase
      @(posedge clk);
      @(negedge clk);
      case (dut)
        0:       obs = out_a;
        1:       obs = out_b;
        default: obs = {3'b000, out_c};
      endcase
      e = exp_q.pop_front();
      chk(tag, {28'd0, obs}, {28'd0, e});
    end
  endtask

  initial begin
    nReset = 1'b0;
    in_a = 4'b0000; clr_a = 1'b0;
    in_b = 4'b0100; clr_b = 1'b0;
    in_c = 1'b0;    clr_c = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_a", {28'd0, out_a}, 32'd0);
    chk("rst_ec_a",  {16'd0, ec_a},  32'd0);
    chk("rst_out_b", {28'd0, out_b}, 32'd0);
    chk("rst_ov_b",  {28'd0, ov_b},  32'd0);
    chk("rst_out_c", {31'd0, out_c}, 32'd0);
    nReset = 1'b1;

    // isolated edge on ch0: exactly 10 high cycles
    for (int n = 0; n < 20; n++)
      push({1'b0, (n == 5) ? 4'b0001 : 4'b0000}, (n >= 5 && n <= 14) ? 4'b0001 : 4'b0000);
    run_seq(0, "a_single");
    chk("a_single_ec", {16'd0, ec_a}, 32'h0001);
    chk("a_single_ov", {28'd0, ov_a}, 32'd0);

    // no retrigger: second edge counted and flagged but pulse not extended
    for (int n = 0; n < 14; n++)
      push({1'b0, (n == 0 || n == 4) ? 4'b0010 : 4'b0000}, (n <= 9) ? 4'b0010 : 4'b0000);
    run_seq(0, "a_noretrig");
    chk("a_noretrig_ec", {16'd0, ec_a}, 32'h0021);
    chk("a_noretrig_ov", {28'd0, ov_a}, 32'h2);

    // retrigger through 2-stage sync: pulse reloads on the second edge
    for (int n = 0; n < 18; n++)
      push({1'b0, (n == 0 || n == 4) ? 4'b0110 : 4'b0100}, (n >= 2 && n <= 15) ? 4'b0010 : 4'b0000);
    run_seq(1, "b_retrig");
    chk("b_retrig_ec", ec_b, 32'h0000_0200);
    chk("b_retrig_ov", {28'd0, ov_b}, 32'h2);

    // active-low ch2: 1->0 starts pulse after sync delay, 0->1 does nothing
    for (int n = 0; n < 22; n++)
      push({1'b0, (n <= 2) ? 4'b0000 : 4'b0100}, (n >= 2 && n <= 11) ? 4'b0100 : 4'b0000);
    run_seq(1, "b_invert");
    chk("b_invert_ec", ec_b, 32'h0001_0200);
    chk("b_invert_ov", {28'd0, ov_b}, 32'h2);

    // 20 edges at period 2 on ch3: 10 high / 2 low, counter saturates at 15
    for (int n = 0; n < 40; n++)
      push({1'b0, ((n % 2) == 0) ? 4'b1000 : 4'b0000}, ((n % 12) < 10) ? 4'b1000 : 4'b0000);
    run_seq(0, "a_sat");
    chk("a_sat_ec", {16'd0, ec_a}, 32'hF021);
    chk("a_sat_ov", {28'd0, ov_a}, 32'hA);

    // clear coinciding with an edge during an active pulse
    push({1'b1, 4'b1000}, 4'b1000);
    run_seq(0, "a_clr");
    chk("a_clr_ec", {16'd0, ec_a}, 32'h1000);
    chk("a_clr_ov", {28'd0, ov_a}, 32'h8);
    for (int n = 41; n < 48; n++)
      push(5'b00000, (n <= 45) ? 4'b1000 : 4'b0000);
    run_seq(0, "a_postclr");
    chk("a_postclr_ec", {16'd0, ec_a}, 32'h1000);

    // stretch of 1 with alternating input: output follows input, no overrun
    for (int n = 0; n < 16; n++)
      push({1'b0, ((n % 2) == 0) ? 4'b0001 : 4'b0000}, ((n % 2) == 0) ? 4'b0001 : 4'b0000);
    push(5'b00000, 4'b0000);
    run_seq(2, "c_toggle");
    chk("c_toggle_ec", {24'd0, ec_c}, 32'd8);
    chk("c_toggle_ov", {31'd0, ov_c}, 32'd0);

    // asynchronous reset in the middle of a pulse
    for (int n = 0; n < 4; n++)
      push({1'b0, (n == 0) ? 4'b0001 : 4'b0000}, 4'b0001);
    run_seq(0, "a_prerst");
    chk("a_prerst_ec", {16'd0, ec_a}, 32'h1001);
    #2 nReset = 1'b0;
    #1;
    chk("a_async_out", {28'd0, out_a}, 32'd0);
    chk("a_async_ec",  {16'd0, ec_a},  32'd0);
    chk("a_async_ov",  {28'd0, ov_a},  32'd0);
    chk("b_async_ec",  ec_b,           32'd0);
    @(negedge clk);
    nReset = 1'b1;
    for (int n = 0; n < 15; n++)
      push(5'b00000, 4'b0000);
    run_seq(0, "a_postrst");
    chk("a_postrst_ec", {16'd0, ec_a}, 32'd0);
    chk("b_postrst_out", {28'd0, out_b}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
